// File: rtl/regs_scoreboard.sv
// Register file with per-register in-flight writer counters and operand forwarding
// from execute and write-back; raises a stall when a source is not yet available.
module regs_scoreboard #(
  parameter int D_BITS    = 32,
  parameter int REG_COUNT = 8,
  parameter int RD_PORTS  = 2,
  parameter int BYPASS    = 1,
  localparam int RA       = $clog2(REG_COUNT)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rd_valid_i,
  input  logic [RD_PORTS*RA-1:0]       rd_src_i,
  input  logic                         rd_dest_en_i,
  input  logic [RA-1:0]                rd_dest_i,
  output logic [RD_PORTS*D_BITS-1:0]   rd_data_o,
  output logic                         rd_stall_o,
  output logic                         rd_issue_o,
  input  logic                         ex_valid_i,
  input  logic                         ex_ready_i,
  input  logic [RA-1:0]                ex_dest_i,
  input  logic [D_BITS-1:0]            ex_data_i,
  input  logic                         wb_valid_i,
  input  logic [RA-1:0]                wb_dest_i,
  input  logic [D_BITS-1:0]            wb_data_i,
  input  logic                         flush_i,
  output logic [REG_COUNT-1:0]         pending_o
);

  logic [D_BITS-1:0]    arr_q [REG_COUNT];
  logic [1:0]           cnt_q [REG_COUNT];
  logic [RD_PORTS-1:0]  port_haz;
  logic [REG_COUNT-1:0] inc_vec;
  logic [REG_COUNT-1:0] dec_vec;
  logic                 dest_full;

  // Per-port operand select: execute result beats write-back data, which beats
  // the array; a pending writer with no forwardable value hazards the port.
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_port
    logic [RA-1:0]     src;
    logic              ex_hit;
    logic              wb_hit;
    logic [D_BITS-1:0] data;
    logic              haz;

    assign src    = rd_src_i[k*RA +: RA];
    assign ex_hit = (BYPASS != 0) && ex_valid_i && (ex_dest_i == src);
    assign wb_hit = (BYPASS != 0) && wb_valid_i && (wb_dest_i == src);

    always_comb begin
      data = arr_q[src];
      haz  = 1'b0;
      if (ex_hit) begin
        if (ex_ready_i) data = ex_data_i;
        else            haz  = 1'b1;
      end else if (wb_hit) begin
        data = wb_data_i;
      end else if (cnt_q[src] != 2'd0) begin
        haz = 1'b1;
      end
    end

    assign rd_data_o[k*D_BITS +: D_BITS] = data;
    assign port_haz[k]                   = haz;
  end

  // Handshake: the read-stage instruction transfers on a cycle where rd_valid_i
  // and rd_issue_o are both high; rd_stall_o is the not-ready indication and
  // rd_issue_o is additionally killed by flush_i and held low during reset.
  assign dest_full  = rd_dest_en_i && (cnt_q[rd_dest_i] == 2'd3);
  assign rd_stall_o = ~rst_i & rd_valid_i & ((|port_haz) | dest_full);
  assign rd_issue_o = ~rst_i & rd_valid_i & ~rd_stall_o & ~flush_i;

  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      inc_vec[r]   = rd_issue_o && rd_dest_en_i && (rd_dest_i == RA'(r));
      dec_vec[r]   = wb_valid_i && (wb_dest_i == RA'(r));
      pending_o[r] = (cnt_q[r] != 2'd0);
    end
  end

  // An issue and a retirement on the same register in one cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        arr_q[r] <= '0;
        cnt_q[r] <= '0;
      end
    end else begin
      if (wb_valid_i) arr_q[wb_dest_i] <= wb_data_i;
      for (int r = 0; r < REG_COUNT; r++) begin
        if (flush_i) begin
          cnt_q[r] <= 2'd0;
        end else if (inc_vec[r] && !dec_vec[r]) begin
          cnt_q[r] <= cnt_q[r] + 2'd1;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != 2'd0)) begin
          cnt_q[r] <= cnt_q[r] - 2'd1;
        end
      end
    end
  end

endmodule
